ascii_to_eightbit: RTL and testbench

ASCII_TO_EIGHTBIT -- requirements
Module: ascii_to_eightbit

---
 rtl/keep_talking_pkg.sv | 34 +++
 rtl/hex_nibble_decode.sv | 30 +++
 rtl/ascii_to_eightbit.sv | 115 +++++++++++
 tb/tb_ascii_to_eightbit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keep_talking_pkg.sv
// Shared character constants, FSM encoding and classifier result type for the
// ASCII hex-pair to byte parser.
package keep_talking_pkg;

   localparam logic [7:0] CH_DIG_LO = 8'h30;
   localparam logic [7:0] CH_DIG_HI = 8'h39;
   localparam logic [7:0] CH_UP_LO  = 8'h41;
   localparam logic [7:0] CH_UP_HI  = 8'h46;
   localparam logic [7:0] CH_LOW_LO = 8'h61;
   localparam logic [7:0] CH_LOW_HI = 8'h66;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_FULL = 2'd2
   } state_t;

   typedef struct packed {
      logic       is_hex;
      logic       is_sep;
      logic [3:0] nibble;
   } char_class_t;

   function automatic logic in_range(input logic [7:0] c,
                                     input logic [7:0] lo,
                                     input logic [7:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/hex_nibble_decode.sv
// Combinational ASCII classifier: hex digit / separator / invalid plus nibble value.
// Latency 0, no backpressure. ASCII_LOWERCASE_EN adds 'a'-'f' as hex digits.
module hex_nibble_decode
   import keep_talking_pkg::*;
(
   input  logic [7:0]  in_char,
   output char_class_t cls
);

   always_comb begin
      cls = '0;
      if (in_range(in_char, CH_DIG_LO, CH_DIG_HI)) begin
         cls.is_hex = 1'b1;
         cls.nibble = in_char[3:0];
      end else if (in_range(in_char, CH_UP_LO, CH_UP_HI)) begin
         // 'A' is 0x41, so the low nibble plus 9 gives 10..15
         cls.is_hex = 1'b1;
         cls.nibble = in_char[3:0] + 4'd9;
`ifdef ASCII_LOWERCASE_EN
      end else if (in_range(in_char, CH_LOW_LO, CH_LOW_HI)) begin
         cls.is_hex = 1'b1;
         cls.nibble = in_char[3:0] + 4'd9;
`endif
      end else if ((in_char == CH_SPACE) || (in_char == CH_COMMA) ||
                   (in_char == CH_CR) || (in_char == CH_LF)) begin
         cls.is_sep = 1'b1;
      end
   end

endmodule

// File: rtl/ascii_to_eightbit.sv
// Parses one or two ASCII hex digits into a byte; out_valid one cycle after the
// completing character, held until out_ready; in_ready low while a byte is pending.
// Optional ASCII_LOWERCASE_EN (in hex_nibble_decode) accepts 'a'-'f'.
module ascii_to_eightbit
   import keep_talking_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_char,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] out_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       err
);

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t           state_q, state_d;
   logic [3:0]       nib_q, nib_d;
   logic [7:0]       byte_q, byte_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   char_class_t cls;
   logic        accept;
   logic        timeout_hit;

   hex_nibble_decode u_decode (
      .in_char (in_char),
      .cls     (cls)
   );

   assign in_ready    = (state_q != ST_FULL);
   assign out_valid   = (state_q == ST_FULL);
   assign out_byte    = byte_q;
   assign err         = err_q;
   assign accept      = in_valid && in_ready;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d = state_q;
      nib_d   = nib_q;
      byte_d  = byte_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (accept) begin
               if (cls.is_hex) begin
                  nib_d   = cls.nibble;
                  state_d = ST_HIGH;
               end else if (!cls.is_sep) begin
                  err_d = 1'b1;
               end
            end
         end
         ST_HIGH: begin
            if (accept) begin
               cnt_d   = '0;
               nib_d   = '0;
               if (cls.is_hex) begin
                  byte_d  = {nib_q, cls.nibble};
                  state_d = ST_FULL;
               end else if (cls.is_sep) begin
                  byte_d  = {4'h0, nib_q};
                  state_d = ST_FULL;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end
            end else if (timeout_hit) begin
               // a character in the same cycle takes priority over the timeout
               err_d   = 1'b1;
               nib_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_FULL: begin
            cnt_d = '0;
            if (out_ready) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            nib_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         nib_q   <= '0;
         byte_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         nib_q   <= nib_d;
         byte_q  <= byte_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_ascii_to_eightbit.sv
// Directed and random bench for ascii_to_eightbit against a character-level
// reference model of the parsing rules (TIMEOUT = 16).
module tb_ascii_to_eightbit;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_char = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_byte;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       err;

   int errors = 0;
   int checks = 0;

   // reference model: held digit (-1 = none), pending byte, quiet cycles in HIGH
   int       m_held = -1;
   bit       m_pend = 0;
   bit [7:0] m_byte = 8'h00;
   bit       m_err  = 0;
   int       m_quiet = 0;

   int       err_cnt = 0;
   int       xfer_cnt = 0;
   bit [7:0] last_xfer = 8'h00;

   ascii_to_eightbit #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_char   (in_char),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_byte  (out_byte),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // -1 = invalid, -2 = separator, 0..15 = hex value
   function automatic int classify(input logic [7:0] c);
      string up = "0123456789ABCDEF";
      string lo = "abcdef";
      for (int i = 0; i < 16; i++) if (c == up[i]) return i;
`ifdef ASCII_LOWERCASE_EN
      for (int i = 0; i < 6; i++) if (c == lo[i]) return 10 + i;
`else
      if (lo.len() < 0) return 0;
`endif
      if (c == " " || c == "," || c == 8'd13 || c == 8'd10) return -2;
      return -1;
   endfunction

   task automatic model_reset();
      m_held = -1; m_pend = 0; m_byte = 8'h00; m_err = 0; m_quiet = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] c, input bit r);
      int k;
      m_err = 0;
      if (m_pend) begin
         if (r) m_pend = 0;
      end else if (v) begin
         k = classify(c);
         if (k >= 0 && m_held < 0) begin
            m_held = k; m_quiet = 0;
         end else if (k >= 0) begin
            m_byte = 8'(m_held * 16 + k); m_pend = 1; m_held = -1;
         end else if (k == -2 && m_held >= 0) begin
            m_byte = 8'(m_held); m_pend = 1; m_held = -1;
         end else if (k == -1) begin
            m_err = 1; m_held = -1;
         end
      end else if (m_held >= 0) begin
         if (m_quiet == TO - 1) begin
            m_held = -1; m_err = 1;
         end else begin
            m_quiet++;
         end
      end
   endtask

   task automatic check_outputs();
      chk("in_ready", {7'h0, in_ready}, {7'h0, !m_pend});
      chk("out_valid", {7'h0, out_valid}, {7'h0, m_pend});
      chk("err", {7'h0, err}, {7'h0, m_err});
      if (m_pend) chk("out_byte", out_byte, m_byte);
      if (err === 1'b1) err_cnt++;
      if (out_valid === 1'b1 && out_ready) begin
         xfer_cnt++;
         last_xfer = out_byte;
      end
   endtask

   task automatic cycle(input bit v, input logic [7:0] c, input bit r);
      in_valid = v; in_char = c; out_ready = r;
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step(v, c, r);
      #1;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, r);
   endtask

   task automatic clr();
      err_cnt = 0; xfer_cnt = 0; last_xfer = 8'h00;
   endtask

   initial begin
      // reset values while rst is held
      @(negedge clk);
      chk("rst_out_valid", {7'h0, out_valid}, 8'h00);
      chk("rst_err", {7'h0, err}, 8'h00);
      chk("rst_out_byte", out_byte, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      idle(2, 1'b1);

      // "3","F"
      clr();
      cycle(1, "3", 1); cycle(1, "F", 1); idle(3, 1);
      chk("s1_bytes", 8'(xfer_cnt), 8'd1);
      chk("s1_value", last_xfer, 8'h3F);
      chk("s1_errs", 8'(err_cnt), 8'd0);

      // leading separator, then "7"," "
      clr();
      cycle(1, " ", 1); cycle(1, "7", 1); cycle(1, " ", 1); idle(3, 1);
      chk("s2_bytes", 8'(xfer_cnt), 8'd1);
      chk("s2_value", last_xfer, 8'h07);
      chk("s2_errs", 8'(err_cnt), 8'd0);

      // "A","G" then "12"
      clr();
      cycle(1, "A", 1); cycle(1, "G", 1); idle(2, 1);
      chk("s3_errs", 8'(err_cnt), 8'd1);
      chk("s3_nobyte", 8'(xfer_cnt), 8'd0);
      cycle(1, "1", 1); cycle(1, "2", 1); idle(3, 1);
      chk("s3_value", last_xfer, 8'h12);

      // "4","2" under backpressure
      clr();
      cycle(1, "4", 0); cycle(1, "2", 0);
      for (int i = 0; i < 10; i++) cycle(1, "9", 0);
      chk("s4_held_nobyte", 8'(xfer_cnt), 8'd0);
      cycle(0, 8'h00, 1); idle(2, 1);
      chk("s4_bytes", 8'(xfer_cnt), 8'd1);
      chk("s4_value", last_xfer, 8'h42);

      // back-to-back pairs: one byte every three cycles
      clr();
      cycle(1, "1", 1); cycle(1, "2", 1); cycle(0, 8'h00, 1);
      cycle(1, "3", 1); cycle(1, "4", 1); cycle(0, 8'h00, 1);
      idle(1, 1);
      chk("s5_bytes", 8'(xfer_cnt), 8'd2);
      chk("s5_value", last_xfer, 8'h34);

      // timeout fires after TO idle cycles in HIGH
      clr();
      cycle(1, "5", 1); idle(TO + 2, 1);
      chk("s6_errs", 8'(err_cnt), 8'd1);
      chk("s6_nobyte", 8'(xfer_cnt), 8'd0);
      // character on the would-be timeout cycle wins
      clr();
      cycle(1, "5", 1); idle(TO - 1, 1); cycle(1, "6", 1); idle(3, 1);
      chk("s7_errs", 8'(err_cnt), 8'd0);
      chk("s7_value", last_xfer, 8'h56);

      // lowercase
      clr();
      cycle(1, "a", 1); cycle(1, "b", 1); idle(3, 1);
`ifdef ASCII_LOWERCASE_EN
      chk("s8_value", last_xfer, 8'hAB);
      chk("s8_errs", 8'(err_cnt), 8'd0);
`else
      chk("s8_errs", 8'(err_cnt), 8'd2);
      chk("s8_nobyte", 8'(xfer_cnt), 8'd0);
`endif

      // reset while a nibble is held
      clr();
      cycle(1, "5", 1);
      rst = 1'b1; #2; rst = 1'b0;
      model_reset();
      idle(TO + 4, 1);
      chk("s9_errs", 8'(err_cnt), 8'd0);
      chk("s9_nobyte", 8'(xfer_cnt), 8'd0);

      // random traffic: busy phase then sparse phase to exercise timeouts
      for (int ph = 0; ph < 2; ph++) begin
         for (int n = 0; n < 1500; n++) begin
            logic [7:0] c;
            int sel;
            bit v, r;
            sel = int'($urandom_range(0, 99));
            if (sel < 45)      c = 8'("0123456789ABCDEF" >> (8 * $urandom_range(0, 15)));
            else if (sel < 60) c = (sel < 52) ? 8'h20 : ((sel < 55) ? 8'h2C : ((sel < 58) ? 8'h0D : 8'h0A));
            else if (sel < 75) c = 8'(8'h61 + $urandom_range(0, 5));
            else               c = 8'($urandom_range(0, 255));
            v = (ph == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 24) == 0);
            r = ($urandom_range(0, 9) < 7);
            cycle(v, c, r);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
